// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared definitions for the multiply/divide unit controller:
//                MDOp operation encoding, default busy-cycle constants and
//                helpers that classify an opcode as multi-cycle work.
//  Config      : MDU_MADD_EN enables the madd/maddu/msub/msubu opcodes; when
//                undefined those codes are reserved.
//  Revision    : 1.0  initial release
// ============================================================================
package mdu_pkg;

  typedef enum logic [3:0] {
    NONE  = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    DIV   = 4'd3,
    DIVU  = 4'd4,
    MFHI  = 4'd5,
    MFLO  = 4'd6,
    MTHI  = 4'd7,
    MTLO  = 4'd8,
    MADD  = 4'd9,
    MADDU = 4'd10,
    MSUB  = 4'd11,
    MSUBU = 4'd12
  } md_op_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // Opcodes that occupy the unit for MULT_CYCLES.
  function automatic logic is_mult_op(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      MULT, MULTU: r = 1'b1;
`ifdef MDU_MADD_EN
      MADD, MADDU, MSUB, MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Opcodes that occupy the unit for DIV_CYCLES.
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_ctrl_if
//  Description : E-stage bus between the pipeline and the multiply/divide
//                unit.
//  Ports       : master (pipeline) drives E_start, E_MDOp, E_A, E_B, D_is_md
//                and observes E_MDout, busy, stall_md, HI, LO.
//                slave (mdu_ctrl) is the mirror image.
//  Revision    : 1.0  initial release
// ============================================================================
interface mdu_ctrl_if;
  logic        E_start;
  logic [3:0]  E_MDOp;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_is_md;
  logic [31:0] E_MDout;
  logic        busy;
  logic        stall_md;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output E_start, E_MDOp, E_A, E_B, D_is_md,
    input  E_MDout, busy, stall_md, HI, LO
  );

  modport slave (
    input  E_start, E_MDOp, E_A, E_B, D_is_md,
    output E_MDout, busy, stall_md, HI, LO
  );
endinterface
`default_nettype wire

// File: rtl/mdu_alu.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_alu
//  Description : Combinational 64-bit arithmetic for the MDU. Produces the
//                value that {HI,LO} takes when the current operation retires.
//                Division by zero and non-arithmetic opcodes return {hi,lo}
//                unchanged, so the controller can always write the result.
//  Config      : MDU_MADD_EN adds madd/maddu/msub/msubu accumulate forms.
//  Ports       : op      in  4   latched operation
//                a, b    in  32  latched rs / rt operands
//                hi, lo  in  32  current HI / LO registers
//                result  out 64  {HI,LO} after the operation
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_alu
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_signed_div;
  logic [31:0] w_num;
  logic [31:0] w_den;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  always_comb begin
    w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    w_prod_u = {32'd0, a} * {32'd0, b};

    // One unsigned divider serves both forms: signed division runs on
    // magnitudes and fixes the signs afterwards. The remainder follows the
    // dividend's sign, the quotient is negative when the signs differ.
    w_signed_div = (op == DIV);
    w_num = (w_signed_div && a[31]) ? (32'd0 - a) : a;
    w_den = (w_signed_div && b[31]) ? (32'd0 - b) : b;
    if (w_den == 32'd0) begin
      w_den = 32'd1;   // keeps the divider defined; result is discarded
    end
    w_uq = w_num / w_den;
    w_ur = w_num % w_den;
    w_quot = (w_signed_div && (a[31] ^ b[31])) ? (32'd0 - w_uq) : w_uq;
    w_rem  = (w_signed_div && a[31]) ? (32'd0 - w_ur) : w_ur;

    result = {hi, lo};
    case (op)
      MULT:  result = w_prod_s;
      MULTU: result = w_prod_u;
      DIV, DIVU: begin
        if (b != 32'd0) begin
          result = {w_rem, w_quot};
        end
      end
`ifdef MDU_MADD_EN
      MADD:  result = {hi, lo} + w_prod_s;
      MADDU: result = {hi, lo} + w_prod_u;
      MSUB:  result = {hi, lo} - w_prod_s;
      MSUBU: result = {hi, lo} - w_prod_u;
`endif
      default: result = {hi, lo};
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_ctrl
//  Description : Multiply/divide unit controller. An IDLE/MULT/DIV FSM with a
//                down-counter holds the unit busy for MULT_CYCLES or
//                DIV_CYCLES after a start, then commits the mdu_alu result to
//                HI/LO. mthi/mtlo write directly from IDLE; mfhi/mflo read
//                combinationally. stall_md holds D/E while the unit is busy
//                or about to become busy.
//  Config      : MDU_MADD_EN enables madd/maddu/msub/msubu.
//  Ports       : clk     in   rising-edge clock
//                reset   in   asynchronous reset, active-low
//                md      slave modport of mdu_ctrl_if (E_start, E_MDOp, E_A,
//                        E_B, D_is_md in; E_MDout, busy, stall_md, HI, LO out)
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  md
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MULT = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic             w_start_mult;
  logic             w_start_div;
  logic             w_last;
  logic             w_busy;
  logic             w_stall;
  logic [31:0]      w_mdout;
  logic [63:0]      w_alu_result;

  assign w_start_mult = md.E_start & is_mult_op(md.E_MDOp);
  assign w_start_div  = md.E_start & is_div_op(md.E_MDOp);
  assign w_last       = (r_cnt == CNT_W'(1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; starts are only honoured from IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_mult) begin
          w_next_state = ST_MULT;
        end else if (w_start_div) begin
          w_next_state = ST_DIV;
        end
      end
      ST_MULT, ST_DIV: begin
        if (w_last) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_busy  = (r_state != ST_IDLE);
    w_stall = md.D_is_md & (w_busy | w_start_mult | w_start_div);
    case (md.E_MDOp)
      MFHI:    w_mdout = r_hi;
      MFLO:    w_mdout = r_lo;
      default: w_mdout = 32'd0;
    endcase
  end

  // Counter, operand latches and HI/LO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_op  <= 4'd0;
      r_a   <= 32'd0;
      r_b   <= 32'd0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_mult || w_start_div) begin
            r_cnt <= w_start_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            r_op  <= md.E_MDOp;
            r_a   <= md.E_A;
            r_b   <= md.E_B;
          end else if (md.E_start && (md.E_MDOp == MTHI)) begin
            r_hi <= md.E_A;
          end else if (md.E_start && (md.E_MDOp == MTLO)) begin
            r_lo <= md.E_A;
          end
        end
        ST_MULT, ST_DIV: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) begin
            {r_hi, r_lo} <= w_alu_result;
          end
        end
        default: ;
      endcase
    end
  end

  mdu_alu u_alu (
    .op     (r_op),
    .a      (r_a),
    .b      (r_b),
    .hi     (r_hi),
    .lo     (r_lo),
    .result (w_alu_result)
  );

  assign md.busy     = w_busy;
  assign md.stall_md = w_stall;
  assign md.E_MDout  = w_mdout;
  assign md.HI       = r_hi;
  assign md.LO       = r_lo;

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5, busy cycles for mult/multu (and madd/msub when enabled).
REQ-002 SHALL provide parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 SHALL provide ports as follows; one clock, reset asynchronous and active-low:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous reset, active-low (0 = reset asserted)
- E_start  in  1  E-stage md instruction valid this cycle, qualified by E_MDOp
- E_MDOp  in  4  operation code (package enum)
- E_A  in  32  rs operand (forwarded)
- E_B  in  32  rt operand (forwarded)
- D_is_md  in  1  D-stage instruction is any md-class op
- E_MDout  out  32  HI or LO for mfhi/mflo in E
- busy  out  1  multi-cycle operation in progress
- stall_md  out  1  stall request to D/E pipeline registers
- HI  out  32  HI register
- LO  out  32  LO register

Function
REQ-004 SHALL implement FSM IDLE, MULT, DIV; IDLE->MULT on E_start with mult-class op; IDLE->DIV on E_start with div-class op; MULT/DIV->IDLE when the counter reaches 1.
REQ-005 SHALL load the counter with MULT_CYCLES or DIV_CYCLES on the start edge and decrement it once per cycle; busy=1 exactly MULT_CYCLES/DIV_CYCLES cycles, starting the cycle after E_start.
REQ-006 SHALL latch operands and op on the start edge; later E_A/E_B changes have no effect.
REQ-007 SHALL update HI/LO on the edge leaving MULT/DIV; values visible the following cycle with busy=0.
REQ-008 SHALL compute mult as signed 32x32->64 and multu as unsigned, {HI,LO}=product.
REQ-009 SHALL compute div/divu as LO=quotient, HI=remainder; signed remainder takes the dividend's sign.
REQ-010 SHALL leave HI/LO unchanged when the divisor is zero; FSM still spends DIV_CYCLES in DIV.
REQ-011 SHALL write HI (mthi) or LO (mtlo) from E_A on the E_start edge when IDLE, without entering busy.
REQ-012 SHALL drive E_MDout combinationally: HI for mfhi, LO for mflo, 0 otherwise.
REQ-013 SHALL drive stall_md = D_is_md & (busy | (E_start & mult/div-class op)).
REQ-014 SHALL ignore E_start while busy; HI/LO and counter unaffected.
REQ-015 SHALL ignore reserved opcodes (no state change, E_MDout=0).

Reset
REQ-016 SHALL on reset=0 immediately force IDLE, counter=0, busy=0, stall_md=0, HI=0, LO=0, latched operands=0, regardless of clk.
REQ-017 SHALL abort an in-flight operation on reset mid-operation; no HI/LO update after reset release.
REQ-018 SHALL accept a start on the first rising edge after reset returns to 1.

Configuration
REQ-019 SHALL, with MDU_MADD_EN defined, support madd/maddu/msub/msubu: {HI,LO} +/- product (signed/unsigned), MULT_CYCLES latency, modulo-2^64 wrap.
REQ-020 SHALL, without MDU_MADD_EN, treat those four opcodes as reserved (REQ-015).

Structure
REQ-021 SHALL place the MDOp enum (NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO, MADD, MADDU, MSUB, MSUBU) and the default cycle constants in shared package mdu_pkg.
REQ-022 SHALL keep FSM/counter inline; arithmetic in one sub-module mdu_alu (combinational 64-bit result from latched operands and op).

Verification
REQ-023 mult E_A=0xFFFFFFFF, E_B=2 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-024 div E_A=-7, E_B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 -> HI/LO unchanged after 10 cycles.
REQ-025 mult then D_is_md=1 (mflo in D) -> stall_md=1 in start cycle and all 5 busy cycles, 0 afterwards; mflo returns LO.
REQ-026 reset=0 asserted in DIV with counter=4 -> busy, HI, LO = 0 without a clk edge; no later update.
REQ-027 mthi E_A=0x12345678 when IDLE -> HI=0x12345678 next cycle, busy stays 0; E_start mult while busy -> ignored.
REQ-028 MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu 1*1 -> HI=1, LO=0; without the macro -> HI/LO unchanged.
